// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit <-> datapath signal bundle
interface multicycle_control_if;
  logic [15:0] instr;
  logic        zero;
  logic        neg;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        wb_sel;
  logic        illegal;
  logic        bus_error;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] pc_inc;
  modport master (
    input  instr, zero, neg, mem_ready,
    output alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_src, mem_read,
           mem_write, reg_write, wb_sel, illegal, bus_error, halted, state, pc_inc
  );
  modport slave (
    output instr, zero, neg, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_src, mem_read,
           mem_write, reg_write, wb_sel, illegal, bus_error, halted, state, pc_inc
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core
module multicycle_control #(
  parameter int PC_INC       = 2,
  parameter int MEM_WAIT_MAX = 255
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;
  state_t     cur, nxt;
  logic [7:0] cnt;
  logic [3:0] op, ex_op;
  logic [1:0] ex_b;
  logic       r_type, is_lw, is_mem, is_br, is_jmp, bad_op, taken, waiting, timeout;
  assign op      = bus.instr[15:12];
  assign r_type  = op <= 4'h5;
  assign is_lw   = op == 4'h7;
  assign is_mem  = op == 4'h7 || op == 4'h8;
  assign is_br   = op == 4'h9 || op == 4'ha;
  assign is_jmp  = op == 4'hb;
  assign bad_op  = op inside {4'hc, 4'hd, 4'he};
  assign taken   = (op == 4'h9 && bus.zero) || (op == 4'ha && bus.neg);
  assign ex_b    = op == 4'h5 ? 2'd3 : r_type ? 2'd0 : 2'd2;
  assign ex_op   = r_type ? op : 4'd0;
  assign waiting = (cur == FETCH || cur == MEM) && !bus.mem_ready;
  assign timeout = waiting && MEM_WAIT_MAX != 0 && cnt == 8'(MEM_WAIT_MAX);
  assign bus.pc_inc = 16'(PC_INC);
  assign bus.state  = reset ? 3'd0 : cur;
  always_ff @(posedge clk)
    if (reset) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= nxt != cur ? '0 : waiting ? cnt + 8'd1 : cnt;
    end
  always_comb begin
    nxt = cur;
    {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.ir_write, bus.pc_write, bus.pc_src,
     bus.mem_read, bus.mem_write, bus.reg_write, bus.wb_sel, bus.illegal, bus.bus_error,
     bus.halted} = '0;
    case (cur)
      FETCH: begin
        bus.alu_src_b = 2'd1;
        bus.mem_read  = !timeout;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        bus.bus_error = timeout;
        nxt = bus.mem_ready ? DECODE : timeout ? HALTED : FETCH;
      end
      DECODE: begin
        bus.illegal = bad_op;
        nxt = op == 4'hf ? HALTED : bad_op ? FETCH : EXEC;
      end
      EXEC: begin
        bus.alu_src_a = !is_jmp;
        bus.alu_src_b = is_br || is_jmp ? 2'd0 : ex_b;
        bus.alu_op    = is_br ? 4'd1 : ex_op;
        bus.pc_write  = is_jmp || taken;
        bus.pc_src    = is_jmp ? 2'd2 : {1'b0, taken};
        nxt = is_mem ? MEM : op <= 4'h6 ? WB : FETCH;
      end
      MEM: begin
        // address selects stay up for the whole access
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        bus.mem_read  = is_lw && !timeout;
        bus.mem_write = !is_lw && !timeout;
        bus.bus_error = timeout;
        nxt = bus.mem_ready ? (is_lw ? WB : FETCH) : timeout ? HALTED : MEM;
      end
      WB: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ex_b;
        bus.alu_op    = ex_op;
        bus.reg_write = 1'b1;
        bus.wb_sel    = is_lw;
        nxt = FETCH;
      end
      HALTED: bus.halted = 1'b1;
      default: nxt = FETCH;
    endcase
    if (reset)
      {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.ir_write, bus.pc_write, bus.pc_src,
       bus.mem_read, bus.mem_write, bus.reg_write, bus.wb_sel, bus.illegal, bus.bus_error,
       bus.halted} = '0;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle trace model of the control unit checked against two DUTs
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  multicycle_control_if a_if ();
  multicycle_control_if b_if ();
  multicycle_control #(.PC_INC(2), .MEM_WAIT_MAX(255)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  multicycle_control #(.PC_INC(2), .MEM_WAIT_MAX(4))   dut_b (.clk(clk), .reset(reset), .bus(b_if));
  logic [20:0] obs_a, obs_b;
  assign obs_a = {a_if.alu_op, a_if.alu_src_a, a_if.alu_src_b, a_if.ir_write, a_if.pc_write, a_if.pc_src,
                  a_if.mem_read, a_if.mem_write, a_if.reg_write, a_if.wb_sel, a_if.illegal,
                  a_if.bus_error, a_if.halted, a_if.state};
  assign obs_b = {b_if.alu_op, b_if.alu_src_a, b_if.alu_src_b, b_if.ir_write, b_if.pc_write, b_if.pc_src,
                  b_if.mem_read, b_if.mem_write, b_if.reg_write, b_if.wb_sel, b_if.illegal,
                  b_if.bus_error, b_if.halted, b_if.state};
  typedef struct {
    bit          rst;
    bit          rdy;
    logic [15:0] ins;
    bit          z;
    bit          n;
    int          sel;
    logic [20:0] ex;
  } cyc_t;
  cyc_t        q[$];
  logic [15:0] cur_ins;
  bit          cur_z, cur_n;
  int          cur_sel = 3;
  int          n_cmp = 0, n_err = 0, ncyc = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [20:0] e(int st, int aop = 0, int sa = 0, int sb = 0, int irw = 0,
                                    int pcw = 0, int pcs = 0, int rd = 0, int wr = 0, int rw = 0,
                                    int wbs = 0, int ill = 0, int be = 0, int hl = 0);
    return {4'(aop), 1'(sa), 2'(sb), 1'(irw), 1'(pcw), 2'(pcs), 1'(rd), 1'(wr), 1'(rw),
            1'(wbs), 1'(ill), 1'(be), 1'(hl), 3'(st)};
  endfunction
  task automatic add(bit rdy, logic [20:0] ex);
    q.push_back('{rst: 1'b0, rdy: rdy, ins: cur_ins, z: cur_z, n: cur_n, sel: cur_sel, ex: ex});
  endtask
  task automatic add_rst();
    q.push_back('{rst: 1'b1, rdy: 1'($urandom), ins: cur_ins, z: cur_z, n: cur_n, sel: 3, ex: '0});
  endtask
  task automatic fetch(int fw);
    repeat (fw) add(1'b0, e(0, 0, 0, 1, 0, 0, 0, 1));
    add(1'b1, e(0, 0, 0, 1, 1, 1, 0, 1));
  endtask
  task automatic halted_for(int k);
    repeat (k) add(1'($urandom), e(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask
  // Expected cycle-by-cycle trace of one instruction, straight from the opcode table
  task automatic instr_seq(logic [15:0] ins, bit z, bit n, int fw, int mw);
    int op, b, aop;
    bit t, lw;
    cur_ins = ins;
    cur_z = z;
    cur_n = n;
    op = int'(ins[15:12]);
    fetch(fw);
    add(1'b0, e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (op >= 12 && op <= 14) ? 1 : 0));
    if (op >= 12) return;
    if (op <= 6) begin
      b = op == 5 ? 3 : op == 6 ? 2 : 0;
      aop = op == 6 ? 0 : op;
      add(1'b0, e(2, aop, 1, b));
      add(1'b0, e(4, aop, 1, b, 0, 0, 0, 0, 0, 1, 0));
    end else if (op == 7 || op == 8) begin
      lw = op == 7;
      add(1'b0, e(2, 0, 1, 2));
      repeat (mw) add(1'b0, e(3, 0, 1, 2, 0, 0, 0, lw, !lw));
      add(1'b1, e(3, 0, 1, 2, 0, 0, 0, lw, !lw));
      if (lw) add(1'b0, e(4, 0, 1, 2, 0, 0, 0, 0, 0, 1, 1));
    end else if (op == 9 || op == 10) begin
      t = op == 9 ? z : n;
      add(1'b0, e(2, 1, 1, 0, 0, t, t));
    end else
      add(1'b0, e(2, 0, 0, 0, 0, 1, 2));
  endtask
  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      reset = c.rst;
      a_if.instr = c.ins;  b_if.instr = c.ins;
      a_if.zero = c.z;     b_if.zero = c.z;
      a_if.neg = c.n;      b_if.neg = c.n;
      a_if.mem_ready = c.rdy;
      b_if.mem_ready = c.rdy;
      @(negedge clk);
      if (c.sel[0]) check($sformatf("dut_a@%0d", ncyc), 32'(obs_a), 32'(c.ex));
      if (c.sel[1]) check($sformatf("dut_b@%0d", ncyc), 32'(obs_b), 32'(c.ex));
      ncyc++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    reset = 1'b1;
    cur_ins = 16'h0000;
    add_rst();
    add_rst();
    // LW interrupted by reset while waiting in MEM
    cur_ins = 16'h7012;
    fetch(0);
    add(1'b0, e(1));
    add(1'b0, e(2, 0, 1, 2));
    add(1'b0, e(3, 0, 1, 2, 0, 0, 0, 1, 0));
    repeat (3) add_rst();
    instr_seq(16'h0123, 0, 0, 1, 0);
    instr_seq(16'h0123, 0, 0, 0, 0);
    instr_seq(16'h7abc, 0, 0, 0, 3);
    instr_seq(16'h8abc, 0, 0, 2, 1);
    instr_seq(16'h5f00, 0, 0, 0, 0);
    instr_seq(16'h6055, 0, 0, 0, 0);
    instr_seq(16'h9111, 1, 0, 0, 0);
    instr_seq(16'h9111, 0, 1, 0, 0);
    instr_seq(16'ha222, 0, 1, 0, 0);
    instr_seq(16'ha222, 1, 0, 0, 0);
    instr_seq(16'hb333, 0, 0, 0, 0);
    instr_seq(16'hc444, 0, 0, 0, 0);
    instr_seq(16'he444, 0, 0, 0, 0);
    run();
    repeat (250) begin
      instr_seq({4'($urandom_range(0, 14)), 12'($urandom)}, 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
      run();
    end
    instr_seq(16'hf000, 0, 0, 1, 0);
    halted_for(25);
    add_rst();
    run();
    // Fetch timeout on the MEM_WAIT_MAX=4 instance, then the same wait with ready on the last cycle
    cur_sel = 2;
    repeat (4) add(1'b0, e(0, 0, 0, 1, 0, 0, 0, 1));
    add(1'b0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    halted_for(6);
    cur_sel = 3;
    add_rst();
    instr_seq(16'h1234, 0, 0, 4, 0);
    instr_seq(16'h7001, 0, 0, 0, 0);
    add_rst();
    run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
